io_ctrl: RTL

Parametrised memory-mapped I/O controller on the CPU data bus, in the same address space as system RAM. It replaces direct key-to-clock/reset wiring with proper input handling:
- two-flop synchronisation of switches and keys;
- per-key debouncing;
- sticky key-press event flags with interrupt request;
- a writable LED register with set/clear/toggle access.

The address decoder in the top level drives `cs` when the CPU addresses the I/O window.

---
 rtl/project_pkg.sv | 8 +
 rtl/io_debounce.sv | 29 ++
 rtl/io_ctrl.sv | 71 +++++++
 3 files changed

// File: rtl/project_pkg.sv
// project_pkg: shared bus word type and I/O register map
package project_pkg;
  typedef logic [7:0] word;
  localparam int IO_ADDR_W = 3;
  typedef enum logic [IO_ADDR_W-1:0] {
    REG_SW, REG_KEY, REG_EVT, REG_IEN, REG_LED, REG_LED_SET, REG_LED_CLR, REG_LED_TGL
  } io_reg_e;
endpackage

// File: rtl/io_debounce.sv
// io_debounce: two-flop synchroniser plus stable-level debouncer with a press pulse
module io_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = $clog2(DB_CYCLES);
  logic s0, s1, done;
  logic [CW-1:0] cnt;
  assign done = (s1 != level) && (cnt == CW'(DB_CYCLES - 1));
  // combinational so the event flag updates on the same edge as level
  assign rise = done && s1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      level <= 1'b0;
      cnt <= '0;
    end else begin
      s0 <= raw;
      s1 <= s0;
      level <= done ? s1 : level;
      cnt <= (s1 == level || done) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/io_ctrl.sv
// io_ctrl: memory-mapped switches, debounced keys with sticky events/irq, and LED register
module io_ctrl
  import project_pkg::*;
#(
  parameter int  N_SW           = 4,
  parameter int  N_KEY          = 2,
  parameter int  N_LED          = 8,
  parameter int  DB_CYCLES      = 50000,
  parameter bit  KEY_ACTIVE_LOW = 1,
  parameter word LED_RST        = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cs,
  input  logic [IO_ADDR_W-1:0] addr,
  input  logic                 wr,
  input  word                  wr_data,
  output word                  rd_data,
  input  logic [N_SW-1:0]      switches,
  input  logic [N_KEY-1:0]     keys,
  output logic [N_LED-1:0]     leds,
  output logic                 irq
);
  io_reg_e reg_sel;
  logic we;
  logic [N_SW-1:0] sw_s0, sw_s1;
  logic [N_KEY-1:0] key_raw, key_lvl, key_rise, evt, ien, evt_nx, ien_nx;
  logic [N_LED-1:0] led, led_nx, wd;
  assign reg_sel = io_reg_e'(addr);
  assign key_raw = KEY_ACTIVE_LOW ? ~keys : keys;
  assign leds = led;
  for (genvar i = 0; i < N_KEY; i++) begin : g_key
    io_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk(clk), .rst(rst), .raw(key_raw[i]), .level(key_lvl[i]), .rise(key_rise[i])
    );
  end
  always_comb begin
    we = cs & wr;
    wd = wr_data[N_LED-1:0];
    // a press arriving with a W1C of the same bit keeps the flag set
    evt_nx = (evt & ~((we && reg_sel == REG_EVT) ? wr_data[N_KEY-1:0] : '0)) | key_rise;
    ien_nx = (we && reg_sel == REG_IEN) ? wr_data[N_KEY-1:0] : ien;
    led_nx = !we                     ? led :
             reg_sel == REG_LED      ? wd :
             reg_sel == REG_LED_SET  ? led | wd :
             reg_sel == REG_LED_CLR  ? led & ~wd :
             reg_sel == REG_LED_TGL  ? led ^ wd : led;
    rd_data = !cs                ? '0 :
              reg_sel == REG_SW  ? word'(sw_s1) :
              reg_sel == REG_KEY ? word'(key_lvl) :
              reg_sel == REG_EVT ? word'(evt) :
              reg_sel == REG_IEN ? word'(ien) :
              reg_sel == REG_LED ? word'(led) : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sw_s0 <= '0;
      sw_s1 <= '0;
      evt <= '0;
      ien <= '0;
      led <= LED_RST[N_LED-1:0];
      irq <= 1'b0;
    end else begin
      sw_s0 <= switches;
      sw_s1 <= sw_s0;
      evt <= evt_nx;
      ien <= ien_nx;
      led <= led_nx;
      irq <= |(evt_nx & ien_nx);
    end
endmodule
